dram_load_controller: RTL



---
 rtl/dram_load_if.sv | 41 ++++
 rtl/dram_load_controller.sv | 134 +++++++++++++
 2 files changed

// File: rtl/dram_load_if.sv
// dram_load_if: start/load handshake, DRAM read port and BRAM write ports of the DRAM load controller
interface dram_load_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 32
);
  logic              dram_access_start;
  logic [ADDR_W-1:0] w_base_addr;
  logic [ADDR_W-1:0] a_base_addr;
  logic [13:0]       w_words;
  logic [9:0]        a_words;
  logic              rd_req_valid;
  logic              rd_req_ready;
  logic [ADDR_W-1:0] rd_req_addr;
  logic [4:0]        rd_req_len;
  logic              rd_data_valid;
  logic [DATA_W-1:0] rd_data;
  logic              rd_data_last;
  logic              w_mem_we;
  logic [12:0]       w_mem_waddr;
  logic [DATA_W-1:0] w_mem_wdata;
  logic              a_mem_we;
  logic [8:0]        a_mem_waddr;
  logic [DATA_W-1:0] a_mem_wdata;
  logic              finish_DRAM_access;
  logic              busy;
  logic              err;
  modport master (
    input  dram_access_start, w_base_addr, a_base_addr, w_words, a_words,
    input  rd_req_ready, rd_data_valid, rd_data, rd_data_last,
    output rd_req_valid, rd_req_addr, rd_req_len,
    output w_mem_we, w_mem_waddr, w_mem_wdata, a_mem_we, a_mem_waddr, a_mem_wdata,
    output finish_DRAM_access, busy, err
  );
  modport slave (
    output dram_access_start, w_base_addr, a_base_addr, w_words, a_words,
    output rd_req_ready, rd_data_valid, rd_data, rd_data_last,
    input  rd_req_valid, rd_req_addr, rd_req_len,
    input  w_mem_we, w_mem_waddr, w_mem_wdata, a_mem_we, a_mem_waddr, a_mem_wdata,
    input  finish_DRAM_access, busy, err
  );
endinterface

// File: rtl/dram_load_controller.sv
// dram_load_controller: streams a weight block then an activation tile from DRAM into BRAMs in max-length bursts
module dram_load_controller #(
  parameter int DATA_W    = 64,
  parameter int ADDR_W    = 32,
  parameter int MAX_BURST = 16
) (
  input logic        clk,
  input logic        rst_n,
  dram_load_if.master bus
);
  typedef enum logic [2:0] {IDLE, W_REQ, W_DATA, A_REQ, A_DATA, DONE, WAIT_LOW} state_t;
  state_t            state_q;
  logic              req_valid_q;
  logic [ADDR_W-1:0] req_addr_q;
  logic [ADDR_W-1:0] a_base_q;
  logic [4:0]        req_len_q;
  logic [4:0]        beat_q;
  logic [13:0]       rem_q;
  logic [9:0]        a_words_q;
  logic [12:0]       ptr_q;
  logic [12:0]       waddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              w_we_q;
  logic              a_we_q;
  logic              finish_q;
  logic              busy_q;
  logic              err_q;
  logic              w_phase;
  logic [ADDR_W-1:0] next_addr_d;
  function automatic logic [4:0] blen(input logic [13:0] r);
    return (r >= 14'(MAX_BURST)) ? 5'(MAX_BURST) : r[4:0];
  endfunction
  assign w_phase     = (state_q == W_REQ) || (state_q == W_DATA);
  assign next_addr_d = req_addr_q + ADDR_W'(req_len_q) * ADDR_W'(DATA_W / 8);
  // Running req_addr_q doubles as the DRAM pointer of the current phase; it only moves on a handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      a_base_q    <= '0;
      req_len_q   <= '0;
      beat_q      <= '0;
      rem_q       <= '0;
      a_words_q   <= '0;
      ptr_q       <= '0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      w_we_q      <= 1'b0;
      a_we_q      <= 1'b0;
      finish_q    <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      w_we_q   <= 1'b0;
      a_we_q   <= 1'b0;
      finish_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.dram_access_start) begin
          busy_q    <= 1'b1;
          err_q     <= 1'b0;
          ptr_q     <= '0;
          a_base_q  <= bus.a_base_addr;
          a_words_q <= bus.a_words;
          if (bus.w_words != 14'd0) begin
            state_q     <= W_REQ;
            req_valid_q <= 1'b1;
            req_addr_q  <= bus.w_base_addr;
            req_len_q   <= blen(bus.w_words);
            rem_q       <= bus.w_words;
          end else if (bus.a_words != 10'd0) begin
            state_q     <= A_REQ;
            req_valid_q <= 1'b1;
            req_addr_q  <= bus.a_base_addr;
            req_len_q   <= blen({4'd0, bus.a_words});
            rem_q       <= {4'd0, bus.a_words};
          end else state_q <= DONE;
        end
        W_REQ, A_REQ: if (bus.rd_req_ready) begin
          req_valid_q <= 1'b0;
          rem_q       <= rem_q - 14'(req_len_q);
          req_addr_q  <= next_addr_d;
          beat_q      <= req_len_q;
          state_q     <= w_phase ? W_DATA : A_DATA;
        end
        W_DATA, A_DATA: if (bus.rd_data_valid) begin
          w_we_q  <= w_phase;
          a_we_q  <= !w_phase;
          waddr_q <= ptr_q;
          wdata_q <= bus.rd_data;
          ptr_q   <= ptr_q + 13'd1;
          beat_q  <= beat_q - 5'd1;
          if (bus.rd_data_last != (beat_q == 5'd1)) err_q <= 1'b1;
          if (beat_q == 5'd1) begin
            if (rem_q != 14'd0) begin
              state_q     <= w_phase ? W_REQ : A_REQ;
              req_valid_q <= 1'b1;
              req_len_q   <= blen(rem_q);
            end else if (w_phase && a_words_q != 10'd0) begin
              state_q     <= A_REQ;
              req_valid_q <= 1'b1;
              req_addr_q  <= a_base_q;
              req_len_q   <= blen({4'd0, a_words_q});
              rem_q       <= {4'd0, a_words_q};
              ptr_q       <= '0;
            end else begin
              state_q  <= DONE;
              finish_q <= 1'b1;
            end
          end
        end
        // Entered with finish already set after a load; a zero-load entry spends one cycle raising it.
        DONE: if (!finish_q) finish_q <= 1'b1; else state_q <= WAIT_LOW;
        WAIT_LOW: if (!bus.dram_access_start) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.rd_req_valid       = req_valid_q;
  assign bus.rd_req_addr        = req_addr_q;
  assign bus.rd_req_len         = req_len_q;
  assign bus.w_mem_we           = w_we_q;
  assign bus.w_mem_waddr        = waddr_q;
  assign bus.w_mem_wdata        = wdata_q;
  assign bus.a_mem_we           = a_we_q;
  assign bus.a_mem_waddr        = waddr_q[8:0];
  assign bus.a_mem_wdata        = wdata_q;
  assign bus.finish_DRAM_access = finish_q;
  assign bus.busy               = busy_q;
  assign bus.err                = err_q;
endmodule
